load_unit: RTL

Read-side counterpart of the store byte-select logic in the MEM stage. Accepts a load micro-op (LB/LBU/LH/LHU/LW) with effective address. Issues a word-aligned read to the data memory port and waits a variable number of cycles for data. Selects and sign/zero-extends the addressed byte or halfword and hands the result to writeback, raising an address-error flag for misaligned loads without touching memory.

---
 rtl/load_unit_pkg.sv | 42 ++++
 rtl/load_extract.sv | 36 +++
 rtl/load_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/load_unit_pkg.sv
// Shared types and load op encodings for the load unit.
// Op values mirror the ALUControl codes used across the pipeline.
package load_unit_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_load(
    input logic [7:0] op
  );
    return (op == EXE_LB_OP)  ||
           (op == EXE_LBU_OP) ||
           (op == EXE_LH_OP)  ||
           (op == EXE_LHU_OP) ||
           (op == EXE_LW_OP);
  endfunction

  function automatic logic misaligned(
    input logic [7:0] op,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    case (op)
      EXE_LH_OP,
      EXE_LHU_OP: r = off[0];
      EXE_LW_OP:  r = |off;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Big-endian lane select and sign/zero extension of a load word.
// Purely combinational so a forwarding path can reuse it.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // pick the addressed lane, then extend per op
  always_comb begin
    b      = word[31:24];
    h      = word[31:16];
    result = word;
    unique case (offset)
      2'b00: b = word[31:24];
      2'b01: b = word[23:16];
      2'b10: b = word[15:8];
      2'b11: b = word[7:0];
    endcase
    h = offset[1] ? word[15:0] : word[31:16];
    case (op)
      EXE_LB_OP:  result = {{24{b[7]}}, b};
      EXE_LBU_OP: result = {24'h0, b};
      EXE_LH_OP:  result = {{16{h[15]}}, h};
      EXE_LHU_OP: result = {16'h0, h};
      default:    result = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: word read, wait for data, extract and respond.
// Misaligned loads answer with adel and never touch memory.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_adel,
  output logic        rsp_buserr,
  output logic        busy
);

  localparam int TW =
    (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TL =
    (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TW-1:0] TLAST = TL[TW-1:0];

  state_t        state;
  state_t        nxt;
  logic [7:0]    op_q;
  logic [1:0]    off_q;
  logic [TW-1:0] cnt;
  logic [31:0]   ext;
  logic          accept;
  logic          misal;
  logic          timeout;

  assign accept  = (state == ST_IDLE) && req_valid
                   && is_load(op);
  assign misal   = misaligned(op, addr[1:0]);
  assign timeout = (MEM_TIMEOUT != 0) && (cnt == TLAST);

  assign req_ready = (state == ST_IDLE);
  assign mem_req   = (state == ST_WAIT);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  load_extract u_extract (
    .op     (op_q),
    .offset (off_q),
    .word   (mem_rdata),
    .result (ext)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept) nxt = misal ? ST_RESP : ST_WAIT;
      ST_WAIT:
        if (mem_data_ok || timeout) nxt = ST_RESP;
      ST_RESP:
        if (rsp_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // request latch, wait counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      off_q      <= '0;
      cnt        <= '0;
      mem_addr   <= '0;
      rsp_data   <= '0;
      rsp_adel   <= 1'b0;
      rsp_buserr <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op;
        off_q      <= addr[1:0];
        cnt        <= '0;
        mem_addr   <= {addr[31:2], 2'b00};
        rsp_data   <= '0;
        rsp_adel   <= misal;
        rsp_buserr <= 1'b0;
      end
      if (state == ST_WAIT) begin
        if (mem_data_ok)
          rsp_data <= ext;
        else if (timeout)
          rsp_buserr <= 1'b1;
        else if (cnt != '1)
          cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
